// File: rtl/hazard_pkg.sv
// Shared constants, the multi-cycle sequencer state type, and the forwarding-select helper
// for the pipeline hazard controller.
package hazard_pkg;

    localparam logic [2:0] FWD_RF = 3'b000;
    localparam logic [2:0] FWD_W  = 3'b001;
    localparam logic [2:0] FWD_M  = 3'b010;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

    // The Memory stage is younger than Writeback, so its value is checked first.
    // x0 is hard-wired to zero and is never forwarded.
    function automatic logic [2:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic [4:0] rd_w,
        input logic       wr_m,
        input logic       wr_w
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_M;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_W;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_mc_timer.sv
// Sequencer for multi-cycle execute operations: freezes the front of the pipe for
// MC_LATENCY cycles, then flags the result as valid for one cycle.
module mc_timer
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    output logic      mc_stall,
    output logic      mc_done,
    output mc_state_t state
);

    localparam int CW = $clog2(MC_LATENCY + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (start) begin
                        cnt   <= CW'(MC_LATENCY - 1);
                        state <= (MC_LATENCY == 1) ? MC_DONE : MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    if (cnt == CW'(1))
                        state <= MC_DONE;
                    else
                        cnt <= cnt - CW'(1);
                end
                // The instruction leaves Execute on this edge; returning to IDLE
                // without looking at start prevents it from re-triggering itself.
                MC_DONE: state <= MC_IDLE;
                default: state <= MC_IDLE;
            endcase
        end
    end

    // The stall begins in the start cycle itself, so it depends on start combinationally.
    assign mc_stall = ((state == MC_IDLE) && start) || (state == MC_BUSY);
    assign mc_done  = (state == MC_DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: execute-stage forwarding, load-use and redirect stall/flush,
// and optional multi-cycle op sequencing (enabled by defining HAZARD_MC_EN).
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MultiCycleE,
    output logic [2:0]  ForwardAE,
    output logic [2:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        McDoneE,
    output logic [31:0] StallCycles
);

    logic mc_stall;
    logic lw_stall;
    logic lw_stall_eff;

`ifdef HAZARD_MC_EN
    mc_state_t mc_state;

    mc_timer #(
        .MC_LATENCY(MC_LATENCY)
    ) u_mc_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (MultiCycleE),
        .mc_stall (mc_stall),
        .mc_done  (McDoneE),
        .state    (mc_state)
    );
`else
    localparam int unused_mc_latency = MC_LATENCY;
    logic unused_mc_start;

    assign unused_mc_start = MultiCycleE;
    assign mc_stall        = 1'b0;
    assign McDoneE         = 1'b0;
`endif

    assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    // A redirect squashes the dependent Decode instruction, and a multi-cycle freeze
    // holds everything anyway, so either one makes the load-use stall moot.
    assign lw_stall_eff = lw_stall && !PCSrcE && !mc_stall;

    assign StallF = mc_stall || lw_stall_eff;
    assign StallD = mc_stall || lw_stall_eff;
    assign StallE = mc_stall;
    assign FlushD = PCSrcE && !mc_stall;
    assign FlushE = (PCSrcE || lw_stall_eff) && !mc_stall;
    assign FlushM = mc_stall;

    always_ff @(posedge clk) begin
        if (rst)
            StallCycles <= '0;
        else if (StallF && (StallCycles != 32'hFFFF_FFFF))
            StallCycles <= StallCycles + 32'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, redirect priority, and
// (when HAZARD_MC_EN is defined) multi-cycle sequencing, back-to-back ops and reset abort.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic        RegWriteM, RegWriteW;
    logic [1:0]  ResultSrcE;
    logic        PCSrcE;
    logic        MultiCycleE;
    logic [2:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE;
    logic        FlushD, FlushE, FlushM;
    logic        McDoneE;
    logic [31:0] StallCycles;

    int          n_checks;
    int          n_errors;
    logic [31:0] exp_stalls;

    hazard_ctrl #(
        .MC_LATENCY(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .Rs1E        (Rs1E),
        .Rs2E        (Rs2E),
        .RdE         (RdE),
        .RdM         (RdM),
        .RdW         (RdW),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .ResultSrcE  (ResultSrcE),
        .PCSrcE      (PCSrcE),
        .MultiCycleE (MultiCycleE),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .McDoneE     (McDoneE),
        .StallCycles (StallCycles)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        RegWriteM = 1'b0; RegWriteW = 1'b0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MultiCycleE = 1'b0;
    endtask

    task automatic check_mc_cycle(input string tag, input logic stall, input logic done);
        @(negedge clk);
        check({tag, "_stallf"}, StallF, stall);
        check({tag, "_stalld"}, StallD, stall);
        check({tag, "_stalle"}, StallE, stall);
        check({tag, "_flushm"}, FlushM, stall);
        check({tag, "_mcdone"}, McDoneE, done);
        if (stall) exp_stalls++;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        exp_stalls = 0;
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        @(negedge clk);
        check("rst_stallf", StallF, 0);
        check("rst_stalle", StallE, 0);
        check("rst_flushm", FlushM, 0);
        check("rst_mcdone", McDoneE, 0);
        check("rst_count", StallCycles, 0);
        check("rst_fwda", ForwardAE, 3'b000);
        rst = 1'b0;
        next_cycle();

        // Forwarding
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd6;
        @(negedge clk);
        check("fwd_a_m_wins", ForwardAE, 3'b010);
        check("fwd_b_none", ForwardBE, 3'b000);
        RegWriteM = 1'b0;
        @(negedge clk);
        check("fwd_a_w", ForwardAE, 3'b001);
        RdM = 5'd0; RdW = 5'd0; RegWriteM = 1'b1; Rs1E = 5'd0;
        @(negedge clk);
        check("fwd_a_x0", ForwardAE, 3'b000);
        RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; RegWriteW = 1'b1; Rs2E = 5'd9;
        @(negedge clk);
        check("fwd_b_w", ForwardBE, 3'b001);
        RegWriteM = 1'b1;
        @(negedge clk);
        check("fwd_b_m", ForwardBE, 3'b010);
        check("fwd_idle_count", StallCycles, exp_stalls);
        clear_inputs();
        next_cycle();

        // Load-use for a single cycle
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        @(negedge clk);
        check("lw_stallf", StallF, 1);
        check("lw_stalld", StallD, 1);
        check("lw_flushe", FlushE, 1);
        check("lw_flushd", FlushD, 0);
        check("lw_stalle", StallE, 0);
        exp_stalls++;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("lw_after_stallf", StallF, 0);
        check("lw_count", StallCycles, exp_stalls);

        ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0;
        @(negedge clk);
        check("lw_x0_stallf", StallF, 0);
        ResultSrcE = 2'b00; RdE = 5'd7; Rs1D = 5'd7;
        @(negedge clk);
        check("lw_notload_stallf", StallF, 0);

        // Redirect beats load-use
        ResultSrcE = 2'b01; PCSrcE = 1'b1;
        @(negedge clk);
        check("br_flushd", FlushD, 1);
        check("br_flushe", FlushE, 1);
        check("br_stallf", StallF, 0);
        check("br_stalld", StallD, 0);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        check("br_count", StallCycles, exp_stalls);
        next_cycle();

`ifdef HAZARD_MC_EN
        // Single op, with a redirect and load-use raised during the freeze
        MultiCycleE = 1'b1;
        check_mc_cycle("mc1_c0", 1, 0);
        next_cycle();
        PCSrcE = 1'b1; ResultSrcE = 2'b01; RdE = 5'd3; Rs1D = 5'd3;
        check_mc_cycle("mc1_c1", 1, 0);
        check("mc1_no_flushd", FlushD, 0);
        check("mc1_no_flushe", FlushE, 0);
        next_cycle();
        PCSrcE = 1'b0; ResultSrcE = 2'b00; RdE = 5'd0; Rs1D = 5'd0;
        check_mc_cycle("mc1_c2", 1, 0);
        next_cycle();
        check_mc_cycle("mc1_done", 0, 1);
        next_cycle();
        MultiCycleE = 1'b0;
        @(negedge clk);
        check("mc1_idle_mcdone", McDoneE, 0);
        check("mc1_count", StallCycles, exp_stalls);
        next_cycle();

        // Back-to-back ops: 3 stalls, advance, 3 stalls, advance
        MultiCycleE = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_mc_cycle($sformatf("b2b_c%0d", i), (i % 4) != 3, (i % 4) == 3);
            next_cycle();
        end
        MultiCycleE = 1'b0;
        @(negedge clk);
        check("b2b_count", StallCycles, exp_stalls);
        check("b2b_idle_stallf", StallF, 0);
        next_cycle();

        // Reset in the middle of an op
        MultiCycleE = 1'b1;
        next_cycle();
        MultiCycleE = 1'b0;
        @(negedge clk);
        check("rstmid_busy_stallf", StallF, 1);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_stalls = 0;
        @(negedge clk);
        check("rstmid_stallf", StallF, 0);
        check("rstmid_stalle", StallE, 0);
        check("rstmid_flushm", FlushM, 0);
        check("rstmid_mcdone", McDoneE, 0);
        check("rstmid_count", StallCycles, 0);
        next_cycle();
        @(negedge clk);
        check("rstmid_stays_idle", StallF, 0);
        check("rstmid_count2", StallCycles, exp_stalls);
`else
        // Without the sequencer, MultiCycleE has no effect
        MultiCycleE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_mc_cycle($sformatf("nomc_c%0d", i), 0, 0);
            next_cycle();
        end
        MultiCycleE = 1'b0;
        @(negedge clk);
        check("nomc_count", StallCycles, exp_stalls);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
